// File: rtl/spmv_sched.sv
// SpMV chunk scheduler: walks the rows of a job, fetching each chunk, issuing it
// to the ALU pipe one at a time and offering one result per completed row.
// state  | meaning
// IDLE   | waiting for start
// FETCH  | chunk read outstanding, fetch_req held
// ISSUE  | chunk presented to the pipe, or skipped when its IPV is empty
// WAIT   | one chunk in flight, timeout counting down
// RESULT | row result offered until the consumer takes it
module spmv_sched #(
   parameter int K     = 4,
   parameter int ROW_W = 8,
   parameter int LAT   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ROW_W-1:0]   num_rows,
   input  logic [3:0]         chunks_per_row,
   input  logic [15:0]        base_addr,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               fetch_req,
   output logic [15:0]        fetch_addr,
   input  logic               fetch_ack,
   input  logic [8*K-1:0]     fetch_data,
   input  logic [K-1:0]       fetch_ipv,
   output logic [8*K-1:0]     pipe_mat,
   output logic [K-1:0]       pipe_ipv,
   output logic               pipe_en,
   input  logic               pipe_out_valid,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [ROW_W-1:0]   res_row
);

   localparam int TW = $clog2(LAT + 2);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_RESULT} state_t;

   state_t           state;
   logic [ROW_W-1:0] rows_q;
   logic [ROW_W-1:0] row;
   logic [3:0]       cpr_q;
   logic [3:0]       chunk;
   logic [K-1:0]     ipv_hold;
   logic [TW-1:0]    timer;

   logic chunk_done;
   logic last_chunk;
   logic last_row;

   // A chunk retires when skipped, when its result returns, or when the wait times out.
   assign chunk_done = ((state == S_ISSUE) && (ipv_hold == '0)) ||
                       ((state == S_WAIT) && (pipe_out_valid || (timer == '0)));
   assign last_chunk = (chunk == cpr_q - 4'd1);
   assign last_row   = (row == rows_q - ROW_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         rows_q     <= '0;
         row        <= '0;
         cpr_q      <= '0;
         chunk      <= '0;
         ipv_hold   <= '0;
         timer      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         fetch_req  <= 1'b0;
         fetch_addr <= '0;
         pipe_mat   <= '0;
         pipe_ipv   <= '0;
         pipe_en    <= 1'b0;
         res_valid  <= 1'b0;
         res_row    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if ((num_rows != '0) && (chunks_per_row != 4'd0)) begin
                     rows_q     <= num_rows;
                     cpr_q      <= chunks_per_row;
                     fetch_addr <= base_addr;
                     row        <= '0;
                     chunk      <= '0;
                     busy       <= 1'b1;
                     fetch_req  <= 1'b1;
                     state      <= S_FETCH;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               if (fetch_ack) begin
                  ipv_hold  <= fetch_ipv;
                  fetch_req <= 1'b0;
                  state     <= S_ISSUE;
                  // Pipe inputs only move for a real issue so they keep the last issued chunk.
                  if (fetch_ipv != '0) begin
                     pipe_mat <= fetch_data;
                     pipe_ipv <= fetch_ipv;
                     pipe_en  <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               pipe_en <= 1'b0;
               if (ipv_hold != '0) begin
                  timer <= TW'(LAT);
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!pipe_out_valid) begin
                  if (timer == '0) err <= 1'b1;
                  else             timer <= timer - TW'(1);
               end
            end
            S_RESULT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (last_row) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     row       <= row + ROW_W'(1);
                     fetch_req <= 1'b1;
                     state     <= S_FETCH;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase

         if (chunk_done) begin
            fetch_addr <= fetch_addr + 16'd1;
            if (last_chunk) begin
               chunk     <= '0;
               res_valid <= 1'b1;
               res_row   <= row;
               state     <= S_RESULT;
            end else begin
               chunk     <= chunk + 4'd1;
               fetch_req <= 1'b1;
               state     <= S_FETCH;
            end
         end
      end
   end

endmodule

// File: tb/tb_spmv_sched.sv
// Directed bench for spmv_sched: table of whole jobs plus hand sequences for
// timeout, result stall with start-while-busy, and reset during WAIT.
module tb_spmv_sched;

   localparam int K     = 4;
   localparam int ROW_W = 8;
   localparam int LAT   = 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic [ROW_W-1:0] num_rows;
   logic [3:0]       chunks_per_row;
   logic [15:0]      base_addr;
   logic             busy;
   logic             done;
   logic             err;
   logic             fetch_req;
   logic [15:0]      fetch_addr;
   logic             fetch_ack;
   logic [8*K-1:0]   fetch_data;
   logic [K-1:0]     fetch_ipv;
   logic [8*K-1:0]   pipe_mat;
   logic [K-1:0]     pipe_ipv;
   logic             pipe_en;
   logic             pipe_out_valid;
   logic             res_valid;
   logic             res_ready;
   logic [ROW_W-1:0] res_row;

   spmv_sched #(.K(K), .ROW_W(ROW_W), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
      .chunks_per_row(chunks_per_row), .base_addr(base_addr),
      .busy(busy), .done(done), .err(err),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
      .fetch_data(fetch_data), .fetch_ipv(fetch_ipv),
      .pipe_mat(pipe_mat), .pipe_ipv(pipe_ipv), .pipe_en(pipe_en),
      .pipe_out_valid(pipe_out_valid),
      .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // knobs owned by the main sequence
   int          withhold    = 0;
   int          ready_delay = 0;
   bit          ready_idle  = 1'b0;
   logic [15:0] zmask       = '0;
   int          job_ack0    = 0;

   // records owned by the responder/monitor
   int               cyc = 0;
   logic [15:0]      q_addr[$];
   int               q_row[$];
   int               n_pe = 0;
   int               n_done = 0;
   int               ack_cnt = 0;
   int               pe_cyc = -1;
   int               err_cyc = -1;
   logic [8*K-1:0]   last_data = '0;
   logic [K-1:0]     last_ipv = '0;
   logic [8*K-1:0]   last_mat = '0;

   initial begin
      int req_cnt;
      int pv_cnt;
      int rv_cnt;
      int idx;
      logic err_q;
      logic [ROW_W-1:0] row_at;
      req_cnt = 0; pv_cnt = 0; rv_cnt = 0; err_q = 1'b0; row_at = '0;
      fetch_ack = 1'b0; fetch_data = '0; fetch_ipv = '0;
      pipe_out_valid = 1'b0; res_ready = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         // memory: ack one cycle after the request is first seen
         fetch_ack = 1'b0;
         if (fetch_req) begin
            if (req_cnt == 1) begin
               idx        = ack_cnt - job_ack0;
               fetch_data = {8'hA5, 8'(ack_cnt), 16'(cyc)};
               fetch_ipv  = (idx == 0) ? 4'b1111 : (4'(ack_cnt) | 4'b0001);
               if (idx >= 0 && idx < 16 && zmask[idx]) fetch_ipv = '0;
               fetch_ack  = 1'b1;
               last_data  = fetch_data;
               last_ipv   = fetch_ipv;
               q_addr.push_back(fetch_addr);
               ack_cnt++;
            end
            req_cnt++;
         end else begin
            req_cnt = 0;
         end
         // pipe: result valid LAT cycles after pipe_en unless withheld
         pipe_out_valid = 1'b0;
         if (pv_cnt > 0) begin
            pv_cnt--;
            if (pv_cnt == 0 && withhold == 0) pipe_out_valid = 1'b1;
         end
         if (pipe_en) begin
            pv_cnt = LAT;
            n_pe++;
            pe_cyc = cyc;
            chk("pipe_mat", pipe_mat, last_data);
            chk("pipe_ipv", pipe_ipv, last_ipv);
            last_mat = last_data;
         end
         if (err && !err_q) err_cyc = cyc;
         err_q = err;
         if (done) n_done++;
         // consumer
         if (res_valid) begin
            if (rv_cnt == 0) row_at = res_row;
            else begin
               chk("res_row_stable", res_row, row_at);
               chk("no_fetch_in_result", fetch_req, 0);
            end
            if (rv_cnt == ready_delay) begin
               res_ready = 1'b1;
               q_row.push_back(int'(res_row));
            end else begin
               res_ready = 1'b0;
            end
            rv_cnt++;
         end else begin
            res_ready = ready_idle;
            rv_cnt = 0;
         end
      end
   end

   typedef struct {
      logic [7:0]  rows;
      logic [3:0]  cpr;
      logic [15:0] base;
      logic [15:0] zm;
      int          rdelay;
      bit          ridle;
      int          exp_fetch;
      int          exp_pe;
      logic [15:0] exp_last;
      int          exp_rows;
   } vec_t;

   vec_t vecs[5];
   int a0, p0, r0, d0;

   task automatic job_launch(input logic [7:0] r, input logic [3:0] c, input logic [15:0] b,
                             input logic [15:0] zm);
      zmask    = zm;
      job_ack0 = ack_cnt;
      a0 = q_addr.size(); p0 = n_pe; r0 = q_row.size(); d0 = n_done;
      num_rows = r; chunks_per_row = c; base_addr = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic job_finish();
      for (int i = 0; i < 3000 && n_done == d0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("done_pulses", n_done - d0, 1);
      chk("busy_after_done", busy, 0);
   endtask

   task automatic job_check(input logic [15:0] b, input int nf, input int npe,
                            input logic [15:0] last, input int nr);
      logic [15:0] ea;
      chk("n_fetch", q_addr.size() - a0, nf);
      for (int i = a0; i < q_addr.size(); i++) begin
         ea = b + 16'(i - a0);
         chk("fetch_addr", q_addr[i], ea);
      end
      if (q_addr.size() > a0) chk("last_addr", q_addr[q_addr.size() - 1], last);
      ea = last + 16'd1;
      chk("addr_after_job", fetch_addr, ea);
      chk("n_pipe_en", n_pe - p0, npe);
      chk("n_rows", q_row.size() - r0, nr);
      for (int i = r0; i < q_row.size(); i++) chk("row_index", q_row[i], i - r0);
      chk("pipe_mat_hold", pipe_mat, last_mat);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_fetch_req"}, fetch_req, 0);
      chk({tag, "_fetch_addr"}, fetch_addr, 0);
      chk({tag, "_pipe_mat"}, pipe_mat, 0);
      chk({tag, "_pipe_ipv"}, pipe_ipv, 0);
      chk({tag, "_pipe_en"}, pipe_en, 0);
      chk({tag, "_res_valid"}, res_valid, 0);
      chk({tag, "_res_row"}, res_row, 0);
   endtask

   task automatic zero_job(input logic [7:0] r, input logic [3:0] c);
      d0 = n_done;
      num_rows = r; chunks_per_row = c; base_addr = 16'h7777; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("zero_done", done, 1);
      chk("zero_fetch_req", fetch_req, 0);
      chk("zero_busy", busy, 0);
      @(negedge clk);
      chk("zero_done_one_cycle", done, 0);
      chk("zero_no_fetch", fetch_req, 0);
   endtask

   initial begin
      vecs[0] = '{8'd1, 4'd2, 16'h0010, 16'h0000, 0, 1'b0, 2, 2, 16'h0011, 1};
      vecs[1] = '{8'd1, 4'd3, 16'h0100, 16'h0002, 0, 1'b0, 3, 2, 16'h0102, 1};
      vecs[2] = '{8'd1, 4'd2, 16'hFFFF, 16'h0000, 0, 1'b1, 2, 2, 16'h0000, 1};
      vecs[3] = '{8'd3, 4'd1, 16'h0200, 16'h0000, 1, 1'b1, 3, 3, 16'h0202, 3};
      vecs[4] = '{8'd2, 4'd2, 16'h0300, 16'h000F, 2, 1'b0, 4, 0, 16'h0303, 2};

      rst = 1'b0; start = 1'b0; num_rows = '0; chunks_per_row = '0; base_addr = '0;
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      rst = 1'b1;
      @(negedge clk);

      foreach (vecs[v]) begin
         ready_delay = vecs[v].rdelay;
         ready_idle  = vecs[v].ridle;
         job_launch(vecs[v].rows, vecs[v].cpr, vecs[v].base, vecs[v].zm);
         job_finish();
         job_check(vecs[v].base, vecs[v].exp_fetch, vecs[v].exp_pe,
                   vecs[v].exp_last, vecs[v].exp_rows);
         chk("err_clear", err, 0);
      end
      ready_delay = 0;
      ready_idle  = 1'b0;

      // pipe result withheld: err at LAT+2 after pipe_en, job still completes
      withhold = 1;
      job_launch(8'd1, 4'd1, 16'h0400, 16'h0000);
      job_finish();
      job_check(16'h0400, 1, 1, 16'h0400, 1);
      chk("err_set", err, 1);
      chk("err_latency", err_cyc - pe_cyc, LAT + 2);
      withhold = 0;
      job_launch(8'd1, 4'd2, 16'h0410, 16'h0000);
      job_finish();
      job_check(16'h0410, 2, 2, 16'h0411, 1);
      chk("err_sticky", err, 1);

      // consumer stalls 5 cycles per row; start while busy must be ignored
      ready_delay = 5;
      job_launch(8'd2, 4'd1, 16'h0500, 16'h0000);
      for (int i = 0; i < 200 && !res_valid; i++) @(negedge clk);
      num_rows = 8'd9; chunks_per_row = 4'd3; base_addr = 16'h9999; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      job_finish();
      job_check(16'h0500, 2, 2, 16'h0501, 2);
      ready_delay = 0;

      // reset while a chunk is in flight
      withhold = 1;
      job_launch(8'd1, 4'd1, 16'h0600, 16'h0000);
      for (int i = 0; i < 200 && n_pe == p0; i++) @(negedge clk);
      chk("wait_reached", n_pe - p0, 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_outputs_zero("midjob_reset");
      @(negedge clk);
      rst = 1'b1;
      withhold = 0;
      repeat (6) @(negedge clk);
      chk("idle_after_reset_busy", busy, 0);
      chk("idle_after_reset_req", fetch_req, 0);
      zero_job(8'd0, 4'd2);
      zero_job(8'd3, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
